serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the maximum word length in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: in_a, in_b and in_last are valid this cycle.
REQ-005 SHALL have port in_a, input, 1 bit: minuend bit, LSB first.
REQ-006 SHALL have port in_b, input, 1 bit: subtrahend bit, LSB first.
REQ-007 SHALL have port in_last, input, 1 bit: this is the word's MSB.
REQ-008 SHALL have port out_valid, output, 1 bit: out_d and out_last are valid.
REQ-009 SHALL have port out_d, output, 1 bit: difference bit, LSB first.
REQ-010 SHALL have port out_last, output, 1 bit: final bit of the word.
REQ-011 SHALL have port borrow, output, 1 bit: final borrow of the word; valid only while out_last is high.
REQ-012 SHALL have port err_len, output, 1 bit: one-cycle pulse when a word is force-terminated.

Function
REQ-013 SHALL compute per accepted bit: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin).
REQ-014 SHALL register every output: an input accepted at edge N appears on the outputs after edge N, which is 1-cycle latency.
REQ-015 SHALL use a two-state FSM with states IDLE (no word open) and RUN (word open).
REQ-016 SHALL clear the borrow register and the bit counter whenever a word closes, so the first bit of every word uses bin = 0.
REQ-017 In IDLE, in_valid with in_last = 0 SHALL move to RUN with count = 1; in_valid with in_last = 1 SHALL stay in IDLE, which is a 1-bit word.
REQ-018 In RUN, in_valid with in_last = 1 SHALL close the word and return to IDLE.
REQ-019 In RUN, in_valid with in_last = 0 when count = WIDTH-1 SHALL force-close the word: out_last = 1 and err_len = 1 for that output cycle, then return to IDLE.
REQ-020 in_valid = 0 SHALL hold state, count and borrow unchanged, so gaps are allowed mid-word; the outputs SHALL show out_valid = 0 for that cycle.
REQ-021 out_last and borrow SHALL equal 0 whenever out_valid = 0.
REQ-022 The block SHALL always accept input and SHALL have no backpressure.

Reset
REQ-023 When rst_n is low, the block SHALL go to IDLE at once, independent of clk, with count = 0 and internal borrow = 0.
REQ-024 When rst_n is low, out_valid, out_d, out_last, borrow and err_len SHALL all be 0.
REQ-025 Reset mid-word SHALL discard the partial word; the first in_valid after release SHALL start a new word.

Configuration
REQ-026 SHALL have macro SERIAL_SUB_PARALLEL_OUT_EN; when defined, the block SHALL add outputs word_valid (1 bit) and diff_word (WIDTH bits).
REQ-027 With SERIAL_SUB_PARALLEL_OUT_EN defined, word_valid SHALL pulse in the same cycle as out_last.
REQ-028 With SERIAL_SUB_PARALLEL_OUT_EN defined, diff_word SHALL hold the full difference; bits above the received length SHALL be 0.
REQ-029 With SERIAL_SUB_PARALLEL_OUT_EN defined, diff_word SHALL hold its value until the next word_valid and SHALL be 0 at reset.
REQ-030 Without SERIAL_SUB_PARALLEL_OUT_EN, the ports word_valid and diff_word and their registers SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-031 Bench SHALL drive WIDTH = 8, a = 5, b = 3 as 8 bits LSB-first, in_last on bit 7 -> out_d bits 0,1,0,0,0,0,0,0 (2), borrow = 0, err_len = 0.
REQ-032 Bench SHALL drive a = 3, b = 5 as 8 bits -> out_d bits give 254, borrow = 1 on out_last; with the macro, diff_word = 8'hFE.
REQ-033 Bench SHALL drive a = 5, b = 3 with in_valid low for 2 cycles after bit 2 -> same result as REQ-031, out_valid low during the gap, no early out_last.
REQ-034 Bench SHALL drive a 1-bit word a = 0, b = 1 with in_last -> out_d = 1, out_last = 1, borrow = 1; the next word's first bit SHALL use bin = 0.
REQ-035 Bench SHALL drive 8 bits without in_last -> out_last = 1 and err_len = 1 on the 8th output; a 9th bit SHALL start a new word.
REQ-036 Bench SHALL pull rst_n low after bit 3 of a 3-minus-5 word -> all outputs 0 immediately; after release, 5 - 3 SHALL give 2 with borrow = 0.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor (a - b), LSB first. Each accepted
//   bit produces one registered difference bit one cycle later. A word closes
//   on in_last. A word that reaches WIDTH bits without in_last is also closed,
//   and err_len pulses for that cycle. The borrow and the bit count are cleared
//   whenever a word closes, so every word starts with borrow-in = 0.
//
//   Optional feature: define SERIAL_SUB_PARALLEL_OUT_EN to add a parallel
//   result (word_valid / diff_word). In the default build the macro is
//   undefined, and these ports and their registers do not exist.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_a / in_b / in_last are valid this cycle
//   in_a       : minuend bit (LSB first)
//   in_b       : subtrahend bit (LSB first)
//   in_last    : this bit is the word's MSB
//   out_valid  : out_d / out_last are valid
//   out_d      : difference bit
//   out_last   : final bit of the word
//   borrow     : final borrow of the word (only meaningful with out_last)
//   err_len    : one-cycle pulse when a word is force-terminated at WIDTH bits
//   word_valid : (optional) pulses together with out_last
//   diff_word  : (optional) full difference, zero above the received length
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_last,
    output logic             out_valid,
    output logic             out_d,
    output logic             out_last,
    output logic             borrow,
    output logic             err_len
`ifdef SERIAL_SUB_PARALLEL_OUT_EN
    ,
    output logic             word_valid,
    output logic [WIDTH-1:0] diff_word
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Full subtractor: returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
        logic d;
        logic bout;
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
        return {bout, d};
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          bin_r;
    logic          bin_nxt_s;
    logic [1:0]    sub_s;
    logic          close_s;

    logic out_valid_r, out_d_r, out_last_r, borrow_r, err_len_r;
    logic out_valid_nxt_s, out_d_nxt_s, out_last_nxt_s, borrow_nxt_s, err_len_nxt_s;

    // Next-state, counter, borrow and output decode for one accepted bit.
    always_comb begin
        state_nxt_s     = state_r;
        count_nxt_s     = count_r;
        bin_nxt_s       = bin_r;
        close_s         = 1'b0;
        out_valid_nxt_s = 1'b0;
        out_d_nxt_s     = 1'b0;
        out_last_nxt_s  = 1'b0;
        borrow_nxt_s    = 1'b0;
        err_len_nxt_s   = 1'b0;
        sub_s           = full_sub(in_a, in_b, bin_r);
        if (in_valid) begin
            out_valid_nxt_s = 1'b1;
            out_d_nxt_s     = sub_s[0];
            case (state_r)
                ST_IDLE: begin
                    if (in_last) begin
                        close_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                        count_nxt_s = {{(CW-1){1'b0}}, 1'b1};
                        bin_nxt_s   = sub_s[1];
                    end
                end
                ST_RUN: begin
                    // Reaching the WIDTH-th bit without in_last force-closes.
                    if (in_last || (count_r == LAST_IDX)) begin
                        close_s       = 1'b1;
                        err_len_nxt_s = ~in_last;
                    end else begin
                        count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
                        bin_nxt_s   = sub_s[1];
                    end
                end
                default: begin
                    close_s = 1'b1;
                end
            endcase
            if (close_s) begin
                state_nxt_s    = ST_IDLE;
                count_nxt_s    = {CW{1'b0}};
                bin_nxt_s      = 1'b0;
                out_last_nxt_s = 1'b1;
                borrow_nxt_s   = sub_s[1];
            end else begin
                out_last_nxt_s = 1'b0;
            end
        end else begin
            // Gap: hold state, count and borrow; outputs idle.
            state_nxt_s = state_r;
            count_nxt_s = count_r;
            bin_nxt_s   = bin_r;
        end
    end

    // State, count, running borrow and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            count_r     <= {CW{1'b0}};
            bin_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_d_r     <= 1'b0;
            out_last_r  <= 1'b0;
            borrow_r    <= 1'b0;
            err_len_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            count_r     <= count_nxt_s;
            bin_r       <= bin_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_d_r     <= out_d_nxt_s;
            out_last_r  <= out_last_nxt_s;
            borrow_r    <= borrow_nxt_s;
            err_len_r   <= err_len_nxt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_d     = out_d_r;
    assign out_last  = out_last_r;
    assign borrow    = borrow_r;
    assign err_len   = err_len_r;

`ifdef SERIAL_SUB_PARALLEL_OUT_EN
    logic [WIDTH-1:0] word_acc_r;
    logic [WIDTH-1:0] word_bits_s;
    logic [WIDTH-1:0] diff_word_r;
    logic             word_valid_r;

    // Insert the current difference bit at its position in the partial word.
    always_comb begin
        word_bits_s          = word_acc_r;
        word_bits_s[count_r] = sub_s[0];
    end

    // Accumulate the partial word; publish and clear it when the word closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_acc_r   <= {WIDTH{1'b0}};
            diff_word_r  <= {WIDTH{1'b0}};
            word_valid_r <= 1'b0;
        end else if (in_valid && close_s) begin
            word_acc_r   <= {WIDTH{1'b0}};
            diff_word_r  <= word_bits_s;
            word_valid_r <= 1'b1;
        end else if (in_valid) begin
            word_acc_r   <= word_bits_s;
            word_valid_r <= 1'b0;
        end else begin
            word_valid_r <= 1'b0;
        end
    end

    assign word_valid = word_valid_r;
    assign diff_word  = diff_word_r;
`endif

endmodule
